irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Per-hart interrupt controller directly downstream of the CLINT. Owns the mip/mie/mideleg CSRs.
//  Merges w_mtip/w_msip from the CLINT with the external M/S interrupt lines.
//  Applies privilege and global enables, selects one interrupt by priority, and holds a trap request
//  to the pipeline under a req/ack handshake. Also produces the WFI wake signal.
// PARAMETERS
//  XLEN       32      CSR data width
//  BLACKOUT   1       cycles the request is forced low after an ack (range 1..7)
// PORTS
//  CLK            in   1     clock
//  RST            in   1     synchronous active-high reset
//  w_mtip         in   1     timer pending from CLINT (level)
//  w_msip         in   1     software pending from CLINT (level)
//  w_meip         in   1     machine external interrupt (level)
//  w_seip         in   1     supervisor external interrupt (level)
//  w_priv         in   2     current privilege level: 0=U, 1=S, 3=M
//  w_mstatus_mie  in   1     mstatus.MIE
//  w_mstatus_sie  in   1     mstatus.SIE
//  w_csr_addr     in   12    CSR address (0x303 mideleg, 0x304 mie, 0x344 mip)
//  w_csr_we       in   1     CSR write strobe
//  w_csr_wdata    in   XLEN  CSR write data
//  w_csr_rdata    out  XLEN  CSR read data, registered, valid 1 cycle after w_csr_addr
//  w_irq_req      out  1     trap request to the pipeline
//  w_irq_cause    out  4     cause code; stable while w_irq_req=1
//  w_irq_to_s     out  1     1 = trap is delegated to S-mode
//  w_irq_ack      in   1     pipeline has taken the trap (sampled only while w_irq_req=1)
//  w_wake         out  1     registered |(mip & mie); ignores global enables and privilege
// BEHAVIOUR
//  Reset: mie=0, mideleg=0, soft SSIP/STIP/SEIP=0, state=IDLE.
//         w_irq_req=0, w_irq_cause=0, w_irq_to_s=0, w_csr_rdata=0, w_wake=0.
//  mip bits:
//   - MSIP[3], MTIP[7], MEIP[11] mirror their inputs and are read-only.
//   - SSIP[1] and STIP[5] are software-writable.
//   - SEIP[9] reads as soft_SEIP | w_seip; a write affects soft_SEIP only.
//  Write masks: mie 0xAAA, mideleg 0x222, mip 0x222. A CSR write takes effect on the next edge.
//  Arbitration is combinational on the current registered CSR state and the current inputs:
//   - pend = mip & mie
//   - M-candidates = pend & ~mideleg; eligible if priv<3 or (priv==3 and MIE=1)
//   - S-candidates = pend & mideleg; eligible if priv==0 or (priv==1 and SIE=1), and only
//     when no M-candidate is eligible
//   - Priority: MEI(11) > MSI(3) > MTI(7) > SEI(9) > SSI(1) > STI(5)
//   - Cause code = bit index
//  FSM IDLE -> REQ -> BLANK -> IDLE:
//   - IDLE: eligible candidate exists -> REQ next cycle. Latch cause and to_s; w_irq_req=1 from
//     that cycle on (1-cycle latency from pending to request).
//   - REQ, w_irq_ack=1 -> BLANK. Ack wins over every simultaneous event.
//   - REQ, no ack, the latched cause is no longer eligible (cleared, masked, or priv/enable change)
//     -> IDLE with w_irq_req=0 (withdraw).
//   - REQ: cause and to_s never change while held. A higher-priority arrival waits for
//     ack or withdraw.
//   - BLANK: w_irq_req=0 for BLACKOUT cycles, then IDLE. This lets the pipeline's mstatus/priv
//     updates land before re-arbitration.
//  An ack while w_irq_req=0 is ignored.
//  Edge-free levels: the block never clears pending itself. MTIP clears only via the CLINT
//  (mtimecmp write); SSIP/STIP clear only via a CSR write.
//  Reset asserted mid-REQ: w_irq_req drops on the next edge with no ack required.
//  w_csr_rdata: registered mux of mip/mie/mideleg; 0 for any other address. A read in the same
//  cycle as a write returns the pre-write value.
// STRUCTURE
//  irq_pkg:
//   - CSR address constants
//   - mip bit indices and cause codes
//   - write masks (0xAAA, 0x222)
//   - state encoding IDLE/REQ/BLANK
//  Sub-module irq_prio_enc: combinational fixed-priority encoder. Takes the 12-bit eligible
//  vector and returns {valid, cause[3:0]}.
//  Everything else (CSRs, FSM, blackout counter) lives in irq_ctrl.
// TESTING
//  1. mie=0x080, priv=M, MIE=1, raise w_mtip -> next cycle req=1, cause=7, to_s=0;
//     ack -> req=0 for BLACKOUT cycles.
//  2. mtip and meip rise together, mie=0x880 -> cause=11. Drop meip before ack -> withdraw
//     (req=0). Next IDLE cycle -> cause=7.
//  3. mideleg=0x020, mie=0x020, priv=S, SIE=1, write mip=0x020 -> cause=5, to_s=1.
//     Same with priv=M -> no request.
//  4. In REQ with cause=7, ack and a mie write of 0 in the same cycle -> BLANK taken.
//     After BLANK, no re-request.
//  5. mie=0x008, priv=M, MIE=0, msip=1 -> req=0 but w_wake=1.
//     CSR read 0x344 -> rdata=0x008 one cycle later.
//  6. RST during REQ -> req=0, mie=0, cause=0 next edge.
//     Write mie=0xFFFF -> readback 0x0AAA.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants and types for the per-hart interrupt controller.
// CSR addresses, mip bit positions/cause codes, write masks and FSM encoding.
package irq_pkg;

  localparam logic [11:0] CSR_MIDELEG = 12'h303;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mip/mie bit index doubles as the interrupt cause code.
  localparam logic [3:0] IRQ_SSI = 4'd1;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_STI = 4'd5;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_SEI = 4'd9;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [11:0] MIE_WMASK     = 12'hAAA;
  localparam logic [11:0] MIDELEG_WMASK = 12'h222;
  localparam logic [11:0] MIP_WMASK     = 12'h222;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BLANK = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder over the eligible interrupt vector.
// Order: MEI > MSI > MTI > SEI > SSI > STI; cause is the winning bit index.
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [11:0] elig,
  output logic        valid,
  output logic [3:0]  cause
);

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    valid = 1'b1;
    cause = 4'd0;
    if      (elig[IRQ_MEI]) cause = IRQ_MEI;
    else if (elig[IRQ_MSI]) cause = IRQ_MSI;
    else if (elig[IRQ_MTI]) cause = IRQ_MTI;
    else if (elig[IRQ_SEI]) cause = IRQ_SEI;
    else if (elig[IRQ_SSI]) cause = IRQ_SSI;
    else if (elig[IRQ_STI]) cause = IRQ_STI;
    else                    valid = 1'b0;
  end

endmodule

// File: rtl/irq_ctrl.sv
// Per-hart interrupt controller: owns mip/mie/mideleg, arbitrates pending interrupts
// and holds one trap request under a req/ack handshake with a post-ack blackout.
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned BLACKOUT = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            w_mtip,
  input  logic            w_msip,
  input  logic            w_meip,
  input  logic            w_seip,
  input  logic [1:0]      w_priv,
  input  logic            w_mstatus_mie,
  input  logic            w_mstatus_sie,
  input  logic [11:0]     w_csr_addr,
  input  logic            w_csr_we,
  input  logic [XLEN-1:0] w_csr_wdata,
  output logic [XLEN-1:0] w_csr_rdata,
  output logic            w_irq_req,
  output logic [3:0]      w_irq_cause,
  output logic            w_irq_to_s,
  input  logic            w_irq_ack,
  output logic            w_wake
);

  logic [11:0]     mie_q, mie_d;
  logic [11:0]     mideleg_q, mideleg_d;
  logic            ssip_q, ssip_d;
  logic            stip_q, stip_d;
  logic            soft_seip_q, soft_seip_d;
  irq_state_e      state_q, state_d;
  logic [3:0]      cause_q, cause_d;
  logic            to_s_q, to_s_d;
  logic [2:0]      blank_cnt_q, blank_cnt_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            wake_q, wake_d;

  logic [11:0] mip;
  logic [11:0] pend;
  logic [11:0] m_elig;
  logic [11:0] s_elig;
  logic [11:0] elig;
  logic        m_en;
  logic        s_en;
  logic        enc_valid;
  logic [3:0]  enc_cause;
  logic        wdata_hi_unused;

  // Only the low 12 bits of CSR write data map onto implemented interrupt bits.
  assign wdata_hi_unused = ^w_csr_wdata[XLEN-1:12];

  always_comb begin
    mip          = '0;
    mip[IRQ_SSI] = ssip_q;
    mip[IRQ_MSI] = w_msip;
    mip[IRQ_STI] = stip_q;
    mip[IRQ_MTI] = w_mtip;
    mip[IRQ_SEI] = soft_seip_q | w_seip;
    mip[IRQ_MEI] = w_meip;
  end

  assign pend = mip & mie_q;

  // M-level interrupts preempt any S-level candidate outright.
  assign m_en   = (w_priv != PRIV_M) || w_mstatus_mie;
  assign s_en   = (w_priv == PRIV_U) || ((w_priv == PRIV_S) && w_mstatus_sie);
  assign m_elig = m_en ? (pend & ~mideleg_q) : '0;
  assign s_elig = (s_en && (m_elig == '0)) ? (pend & mideleg_q) : '0;
  assign elig   = m_elig | s_elig;

  irq_prio_enc u_prio_enc (
    .elig  (elig),
    .valid (enc_valid),
    .cause (enc_cause)
  );

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    to_s_d      = to_s_q;
    blank_cnt_d = blank_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_REQ;
          cause_d = enc_cause;
          to_s_d  = (s_elig != '0);
        end
      end
      ST_REQ: begin
        // Ack outranks a simultaneous withdraw condition.
        if (w_irq_ack) begin
          state_d     = ST_BLANK;
          blank_cnt_d = 3'(BLACKOUT - 1);
        end else if (!elig[cause_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == 3'd0) state_d = ST_IDLE;
        else                     blank_cnt_d = blank_cnt_q - 3'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mie_d       = mie_q;
    mideleg_d   = mideleg_q;
    ssip_d      = ssip_q;
    stip_d      = stip_q;
    soft_seip_d = soft_seip_q;
    if (w_csr_we) begin
      unique case (w_csr_addr)
        CSR_MIE:     mie_d     = w_csr_wdata[11:0] & MIE_WMASK;
        CSR_MIDELEG: mideleg_d = w_csr_wdata[11:0] & MIDELEG_WMASK;
        CSR_MIP: begin
          ssip_d      = w_csr_wdata[IRQ_SSI] & MIP_WMASK[IRQ_SSI];
          stip_d      = w_csr_wdata[IRQ_STI] & MIP_WMASK[IRQ_STI];
          soft_seip_d = w_csr_wdata[IRQ_SEI] & MIP_WMASK[IRQ_SEI];
        end
        default: ;
      endcase
    end
  end

  // Read path samples pre-write state, so a same-cycle write is not visible yet.
  always_comb begin
    rdata_d = '0;
    unique case (w_csr_addr)
      CSR_MIE:     rdata_d = XLEN'(mie_q);
      CSR_MIDELEG: rdata_d = XLEN'(mideleg_q);
      CSR_MIP:     rdata_d = XLEN'(mip);
      default:     rdata_d = '0;
    endcase
  end

  assign wake_d = |pend;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mie_q       <= '0;
      mideleg_q   <= '0;
      ssip_q      <= 1'b0;
      stip_q      <= 1'b0;
      soft_seip_q <= 1'b0;
      state_q     <= ST_IDLE;
      cause_q     <= '0;
      to_s_q      <= 1'b0;
      blank_cnt_q <= '0;
      rdata_q     <= '0;
      wake_q      <= 1'b0;
    end else begin
      mie_q       <= mie_d;
      mideleg_q   <= mideleg_d;
      ssip_q      <= ssip_d;
      stip_q      <= stip_d;
      soft_seip_q <= soft_seip_d;
      state_q     <= state_d;
      cause_q     <= cause_d;
      to_s_q      <= to_s_d;
      blank_cnt_q <= blank_cnt_d;
      rdata_q     <= rdata_d;
      wake_q      <= wake_d;
    end
  end

  assign w_irq_req   = (state_q == ST_REQ);
  assign w_irq_cause = cause_q;
  assign w_irq_to_s  = to_s_q;
  assign w_csr_rdata = rdata_q;
  assign w_wake      = wake_q;

endmodule
